// File: rtl/lane_scheduler_2to1.sv
// rtl/lane_scheduler_2to1.sv - round-robin merge of two buffered byte lanes onto one valid-tagged stream
module lane_scheduler_2to1 #(
    parameter int                DATA_W     = 8,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] IDLE_BYTE  = 8'hBC
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_00,
    input  logic              valid_00,
    input  logic [DATA_W-1:0] data_11,
    input  logic              valid_11,
    input  logic              enable,
    output logic [DATA_W-1:0] data_000,
    output logic              valid_000,
    output logic              lane_sel,
    output logic              full_0,
    output logic              full_1,
    output logic              overflow_0,
    output logic              overflow_1
);
    localparam int           AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]  DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [2][FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr [2];
    logic [AW-1:0]     rd_ptr [2];
    logic [AW:0]       count [2];
    logic [AW:0]       count_nxt [2];
    logic              full_r [2];
    logic              ovf_r [2];
    logic              last_grant;

    logic              vin [2];
    logic [DATA_W-1:0] din [2];
    logic              push [2];
    logic              pop [2];
    logic              drop [2];
    logic              grant;
    logic              grant_lane;
    logic [DATA_W-1:0] head;

    assign vin[0] = valid_00;
    assign vin[1] = valid_11;
    assign din[0] = data_00;
    assign din[1] = data_11;

    // Arbitration looks only at pre-edge counts, so a byte written this edge cannot be popped until the next.
    always_comb begin
        grant      = 1'b0;
        grant_lane = 1'b0;
        if (enable) begin
            if (count[0] != '0 && count[1] != '0) begin
                grant      = 1'b1;
                grant_lane = ~last_grant;
            end else if (count[0] != '0) begin
                grant      = 1'b1;
                grant_lane = 1'b0;
            end else if (count[1] != '0) begin
                grant      = 1'b1;
                grant_lane = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            pop[i]       = grant && (grant_lane == 1'(i));
            push[i]      = vin[i] && (count[i] != DEPTH_C || pop[i]);
            drop[i]      = vin[i] && !push[i];
            count_nxt[i] = count[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
        end
    end

    assign head = grant_lane ? mem[1][rd_ptr[1]] : mem[0][rd_ptr[0]];

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= din[i];
                end
            end
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
                full_r[i] <= 1'b0;
                ovf_r[i]  <= 1'b0;
            end
            last_grant <= 1'b1;
            data_000   <= IDLE_BYTE;
            valid_000  <= 1'b0;
            lane_sel   <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + AW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                end
                count[i]  <= count_nxt[i];
                full_r[i] <= (count_nxt[i] == DEPTH_C);
                if (drop[i]) begin
                    ovf_r[i] <= 1'b1;
                end
            end
            if (grant) begin
                data_000   <= head;
                valid_000  <= 1'b1;
                lane_sel   <= grant_lane;
                last_grant <= grant_lane;
            end else begin
                data_000  <= IDLE_BYTE;
                valid_000 <= 1'b0;
            end
        end
    end

    assign full_0     = full_r[0];
    assign full_1     = full_r[1];
    assign overflow_0 = ovf_r[0];
    assign overflow_1 = ovf_r[1];
endmodule

// File: tb/tb_lane_scheduler_2to1.sv
// tb/tb_lane_scheduler_2to1.sv - self-checking bench for lane_scheduler_2to1
module tb_lane_scheduler_2to1;
    logic       clk_4f = 1'b0;
    logic       reset, valid_00, valid_11, enable;
    logic [7:0] data_00, data_11, data_000;
    logic       valid_000, lane_sel, full_0, full_1, overflow_0, overflow_1;

    always #5 clk_4f = ~clk_4f;

    lane_scheduler_2to1 dut (
        .clk_4f(clk_4f), .reset(reset),
        .data_00(data_00), .valid_00(valid_00),
        .data_11(data_11), .valid_11(valid_11),
        .enable(enable),
        .data_000(data_000), .valid_000(valid_000), .lane_sel(lane_sel),
        .full_0(full_0), .full_1(full_1),
        .overflow_0(overflow_0), .overflow_1(overflow_1)
    );

    typedef struct {
        logic       rst, en, v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       ev;
        logic [7:0] ed;
        logic       es;
    } vec_t;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       s, f0, f1, o0, o1;
    } exp_t;

    vec_t       vecs[$];
    exp_t       sb[$];
    logic [7:0] mq0[$], mq1[$];
    logic       m_last, m_sel, m_o0, m_o1;
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drives one edge, predicts it with a queue-based lane model, then checks the DUT against the prediction.
    task automatic step(input logic rst, input logic en, input logic v0, input logic [7:0] d0,
                        input logic v1, input logic [7:0] d1);
        exp_t e;
        logic g, gl;
        @(negedge clk_4f);
        reset = rst; enable = en; valid_00 = v0; data_00 = d0; valid_11 = v1; data_11 = d1;
        if (rst) begin
            mq0.delete(); mq1.delete();
            m_last = 1'b1; m_sel = 1'b0; m_o0 = 1'b0; m_o1 = 1'b0;
            e.v = 1'b0; e.d = 8'hBC;
        end else begin
            g = 1'b0; gl = 1'b0;
            if (en) begin
                if (mq0.size() > 0 && mq1.size() > 0) begin g = 1'b1; gl = ~m_last; end
                else if (mq0.size() > 0) begin g = 1'b1; gl = 1'b0; end
                else if (mq1.size() > 0) begin g = 1'b1; gl = 1'b1; end
            end
            if (g) begin
                e.v = 1'b1;
                if (gl) e.d = mq1.pop_front();
                else    e.d = mq0.pop_front();
                m_sel = gl; m_last = gl;
            end else begin
                e.v = 1'b0; e.d = 8'hBC;
            end
            if (v0) begin if (mq0.size() < 4) mq0.push_back(d0); else m_o0 = 1'b1; end
            if (v1) begin if (mq1.size() < 4) mq1.push_back(d1); else m_o1 = 1'b1; end
        end
        e.s = m_sel; e.f0 = (mq0.size() == 4); e.f1 = (mq1.size() == 4); e.o0 = m_o0; e.o1 = m_o1;
        sb.push_back(e);
        @(posedge clk_4f); #1;
        e = sb.pop_front();
        chk("sb_valid_000", {7'd0, valid_000}, {7'd0, e.v});
        chk("sb_data_000", data_000, e.d);
        chk("sb_lane_sel", {7'd0, lane_sel}, {7'd0, e.s});
        chk("sb_full_0", {7'd0, full_0}, {7'd0, e.f0});
        chk("sb_full_1", {7'd0, full_1}, {7'd0, e.f1});
        chk("sb_overflow_0", {7'd0, overflow_0}, {7'd0, e.o0});
        chk("sb_overflow_1", {7'd0, overflow_1}, {7'd0, e.o1});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; valid_00 = 1'b0; valid_11 = 1'b0; data_00 = 8'h00; data_11 = 8'h00;
        m_last = 1'b1; m_sel = 1'b0; m_o0 = 1'b0; m_o1 = 1'b0;

        // reset with writes asserted, then a lane 0 stream, then a two-lane interleave
        vecs.push_back('{1, 1, 1, 8'h11, 1, 8'h22, 0, 8'hBC, 0});
        vecs.push_back('{1, 1, 1, 8'h33, 1, 8'h44, 0, 8'hBC, 0});
        vecs.push_back('{0, 1, 1, 8'hFF, 0, 8'h00, 0, 8'hBC, 0});
        vecs.push_back('{0, 1, 1, 8'hBB, 0, 8'h00, 1, 8'hFF, 0});
        vecs.push_back('{0, 1, 1, 8'hEA, 0, 8'h00, 1, 8'hBB, 0});
        vecs.push_back('{0, 1, 1, 8'hCC, 0, 8'h00, 1, 8'hEA, 0});
        vecs.push_back('{0, 1, 1, 8'h15, 0, 8'h00, 1, 8'hCC, 0});
        vecs.push_back('{0, 1, 1, 8'h16, 0, 8'h00, 1, 8'h15, 0});
        vecs.push_back('{0, 1, 0, 8'h00, 0, 8'h00, 1, 8'h16, 0});
        vecs.push_back('{0, 1, 0, 8'h00, 0, 8'h00, 0, 8'hBC, 0});
        vecs.push_back('{1, 1, 0, 8'h00, 0, 8'h00, 0, 8'hBC, 0});
        vecs.push_back('{0, 1, 1, 8'hFF, 1, 8'hEE, 0, 8'hBC, 0});
        vecs.push_back('{0, 1, 1, 8'hBB, 1, 8'hAA, 1, 8'hFF, 0});
        vecs.push_back('{0, 1, 0, 8'h00, 0, 8'h00, 1, 8'hEE, 1});
        vecs.push_back('{0, 1, 0, 8'h00, 0, 8'h00, 1, 8'hBB, 0});
        vecs.push_back('{0, 1, 0, 8'h00, 0, 8'h00, 1, 8'hAA, 1});
        vecs.push_back('{0, 1, 0, 8'h00, 0, 8'h00, 0, 8'hBC, 1});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1);
            chk($sformatf("tbl%0d_valid", i), {7'd0, valid_000}, {7'd0, vecs[i].ev});
            chk($sformatf("tbl%0d_data", i), data_000, vecs[i].ed);
            chk($sformatf("tbl%0d_sel", i), {7'd0, lane_sel}, {7'd0, vecs[i].es});
        end

        // lane 1 overflows while held, then drains
        step(1, 0, 0, 8'h00, 0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 8'h00, 1, 8'h20 + 8'(i));
            if (i == 3) chk("t4_full_1", {7'd0, full_1}, 8'd1);
        end
        chk("t4_overflow_1", {7'd0, overflow_1}, 8'd1);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 8'h00, 0, 8'h00);
            chk("t4_drain_data", data_000, 8'h20 + 8'(i));
            chk("t4_drain_sel", {7'd0, lane_sel}, 8'd1);
        end
        step(0, 1, 0, 8'h00, 0, 8'h00);
        chk("t4_idle_valid", {7'd0, valid_000}, 8'd0);
        chk("t4_overflow_sticky", {7'd0, overflow_1}, 8'd1);

        // write into a full lane 0 on the same edge it is popped
        step(1, 0, 0, 8'h00, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h01 + 8'(i), 0, 8'h00);
        chk("t5_full_0", {7'd0, full_0}, 8'd1);
        step(0, 1, 1, 8'h55, 0, 8'h00);
        chk("t5_first", data_000, 8'h01);
        chk("t5_overflow_0", {7'd0, overflow_0}, 8'd0);
        chk("t5_full_hold", {7'd0, full_0}, 8'd1);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 8'h00, 0, 8'h00);
            chk("t5_drain", data_000, (i == 3) ? 8'h55 : 8'h02 + 8'(i));
        end
        step(0, 1, 0, 8'h00, 0, 8'h00);
        chk("t5_idle_valid", {7'd0, valid_000}, 8'd0);

        // reset mid-drain discards queued bytes
        step(1, 0, 0, 8'h00, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'hA1 + 8'(i), 0, 8'h00);
        step(0, 1, 0, 8'h00, 0, 8'h00);
        chk("t6_first", data_000, 8'hA1);
        step(1, 1, 0, 8'h00, 0, 8'h00);
        chk("t6_rst_valid", {7'd0, valid_000}, 8'd0);
        chk("t6_rst_data", data_000, 8'hBC);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 8'h00, 0, 8'h00);
            chk("t6_no_stale", {7'd0, valid_000}, 8'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/lane_scheduler_2to1.md
Name: lane_scheduler_2to1

Overview:
Round-robin scheduler that merges the two post-demux byte lanes (lane 0: data_00/valid_00, lane 1: data_11/valid_11) onto the single valid-tagged output stream data_000/valid_000 in the phy_rx path. Each lane has a small input FIFO that absorbs bursts. The scheduler grants one lane per clk_4f cycle and fills idle cycles with IDLE_BYTE. Overflow is detected per lane and reported as a sticky flag.

Parameters:
DATA_W, 8, byte width of all data ports
FIFO_DEPTH, 4, entries per lane FIFO; must be a power of 2, minimum 2
IDLE_BYTE, 8'hBC, value driven on data_000 when valid_000=0

Ports:
clk_4f  in  1  single clock, rising-edge
reset  in  1  synchronous, active-high reset
data_00  in  DATA_W  lane 0 input byte
valid_00  in  1  lane 0 write strobe
data_11  in  DATA_W  lane 1 input byte
valid_11  in  1  lane 1 write strobe
enable  in  1  1 = scheduler may pop; 0 = hold FIFOs, output idle
data_000  out  DATA_W  merged output byte (registered)
valid_000  out  1  merged output valid (registered)
lane_sel  out  1  lane that sourced the current data_000
full_0  out  1  lane 0 FIFO count == FIFO_DEPTH
full_1  out  1  lane 1 FIFO count == FIFO_DEPTH
overflow_0  out  1  sticky: lane 0 write was dropped
overflow_1  out  1  sticky: lane 1 write was dropped

Behaviour:
- Single clock domain: clk_4f. Reset is synchronous and active-high. All state changes on the rising edge of clk_4f.
- Reset values:
  - FIFO pointers and counts = 0
  - last_grant = 1, so lane 0 wins the first contention
  - data_000 = IDLE_BYTE
  - valid_000 = 0
  - lane_sel = 0
  - full_x = 0
  - overflow_x = 0
- Reset overrides all inputs. No write is accepted during a reset cycle, and stored bytes are discarded.
- Write side, per lane x:
  - If valid_x=1 and the lane's count < FIFO_DEPTH, push data_x.
  - If the lane's count == FIFO_DEPTH and that lane is popped in the same cycle, the push is also accepted. Count stays at FIFO_DEPTH and no overflow is flagged.
  - Otherwise the byte is dropped and overflow_x is set to 1. overflow_x clears only on reset.
- There is no bypass path. A byte pushed at edge N is first eligible for a pop at edge N+1, so minimum latency from input strobe to valid_000 is 2 edges.
- Arbitration, evaluated each edge with enable=1, using counts before this edge's pushes:
  - Both lanes non-empty: grant the lane != last_grant.
  - Exactly one lane non-empty: grant that lane.
  - Neither lane non-empty: no grant.
  - last_grant updates only when a grant occurs.
- Output register:
  - On a grant: data_000 <= FIFO head, valid_000 <= 1, lane_sel <= granted lane, and that lane's read pointer increments.
  - With no grant, or with enable=0: data_000 <= IDLE_BYTE, valid_000 <= 0, lane_sel holds its value.
- enable=0 does not block writes. FIFOs keep filling and may overflow.
- Pointers wrap modulo FIFO_DEPTH. Counts are log2(FIFO_DEPTH)+1 bits wide and never exceed FIFO_DEPTH or go below 0.
- full_x is registered and reflects the post-edge count.
- Reset mid-burst: the next edge after reset deasserts outputs idle data. No stale bytes are emitted after release.

Test Plan:
1. Hold reset 2 cycles with valid_00=valid_11=1 -> data_000=8'hBC, valid_000=0, full/overflow=0. After release, the first valid output is a post-reset byte.
2. Lane 0 only, enable=1, writes FF,BB,EA,CC,15,16 on consecutive edges -> data_000 shows the same sequence starting 2 edges after the first write, valid_000=1 throughout, lane_sel=0, then BC/valid 0.
3. Both lanes write FF/EE then BB/AA on the same edges -> output order FF,EE,BB,AA with lane_sel 0,1,0,1.
4. enable=0, lane 1 writes 5 bytes 20..24 -> full_1=1 after the 4th write, 24 dropped, overflow_1=1. Raise enable -> 20,21,22,23 output, then idle; overflow_1 stays 1.
5. Lane 0 full (count 4), enable=1, lane 1 empty, write 8'h55 in the same cycle as the pop -> accepted, overflow_0=0, 55 emerges after the 4 stored bytes.
6. Three bytes queued in lane 0, assert reset one cycle mid-drain -> valid_000=0 and data_000=BC on the next edge, no queued byte appears afterwards.
